// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared types and sizing helpers for the PWM set sequencer
package pwm_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } seq_state_t;

   localparam int CH_NUM_DEF    = 4;
   localparam int CRX_WIDTH_DEF = 16;
   localparam int SET_WIDTH     = CH_NUM_DEF * CRX_WIDTH_DEF;

   // Occupancy must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pwm_seq_fifo.sv
// rtl/pwm_seq_fifo.sv - first-word fall-through set FIFO with flush
module pwm_seq_fifo
   import pwm_seq_pkg::*;
#(
   parameter int W     = SET_WIDTH,
   parameter int DEPTH = 8,
   parameter int CW    = occ_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// rtl/pwm_seq_ctrl.sv - period-synchronous compare-set sequencer for the 4-channel PWM timer
module pwm_seq_ctrl
   import pwm_seq_pkg::*;
#(
   parameter int CRX_WIDTH  = CRX_WIDTH_DEF,
   parameter int CH_NUM     = CH_NUM_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter int RPT_WIDTH  = 8,
   parameter int LW_THRESH  = 2,
   parameter int CW         = occ_width(FIFO_DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic                        start_i,
   input  logic                        stop_i,
   input  logic                        flush_i,
   input  logic [RPT_WIDTH-1:0]        rpt_i,
   input  logic                        wr_valid_i,
   output logic                        wr_ready_o,
   input  logic [CH_NUM*CRX_WIDTH-1:0] wr_data_i,
   input  logic                        period_end_i,
   output logic [CH_NUM*CRX_WIDTH-1:0] cr_o,
   output logic                        cr_upd_o,
   output logic                        busy_o,
   output logic [CW-1:0]               elem_cnt_o,
   output logic                        lw_o,
   output logic                        udf_o,
   input  logic                        udf_clr_i
);

   localparam int WORD_W = CH_NUM * CRX_WIDTH;

   seq_state_t            state;
   logic [RPT_WIDTH-1:0]  hold;
   logic [WORD_W-1:0]     head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  period_act;
   logic                  pop;
   logic                  udf_set;

   assign wr_ready_o = !fifo_full;
   assign busy_o     = (state != IDLE);

   // A period boundary only counts when the sequencer is live and not being stopped.
   assign period_act = period_end_i && !stop_i && (state != IDLE);
   assign pop        = period_act && !fifo_empty &&
                       ((state == ARMED) || ((state == RUN) && (hold == '0)));
   assign udf_set    = period_act && fifo_empty && (state == RUN) && (hold == '0);

   pwm_seq_fifo #(
      .W     (WORD_W),
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .push  (wr_valid_i),
      .pop   (pop),
      .flush (flush_i),
      .wdata (wr_data_i),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (elem_cnt_o)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= IDLE;
         cr_o     <= '0;
         hold     <= '0;
         cr_upd_o <= 1'b0;
         udf_o    <= 1'b0;
         lw_o     <= 1'b0;
      end else begin
         cr_upd_o <= 1'b0;
         lw_o     <= busy_o && (elem_cnt_o <= CW'(LW_THRESH));

         if (udf_set)        udf_o <= 1'b1;
         else if (udf_clr_i) udf_o <= 1'b0;

         if (pop) begin
            cr_o     <= head;
            cr_upd_o <= 1'b1;
            hold     <= (rpt_i == '0) ? '0 : rpt_i - 1'b1;
         end else if (period_act && (state == RUN) && (hold != '0)) begin
            hold <= hold - 1'b1;
         end

         if (stop_i) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE:    if (start_i) state <= ARMED;
               ARMED:   if (pop) state <= RUN;
               RUN:     if (udf_set) state <= ARMED;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb/tb_pwm_seq_ctrl.sv - directed self-checking bench for pwm_seq_ctrl
module tb_pwm_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  rpt = 8'd0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [63:0] wr_data = '0;
   logic        period_end = 1'b0;
   logic [63:0] cr;
   logic        cr_upd;
   logic        busy;
   logic [3:0]  elem_cnt;
   logic        lw;
   logic        udf;
   logic        udf_clr = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   logic [63:0] set_a, set_b, set_c, set_d, set_e, set_g;

   always #5 clk = ~clk;

   pwm_seq_ctrl dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .start_i      (start),
      .stop_i       (stop),
      .flush_i      (flush),
      .rpt_i        (rpt),
      .wr_valid_i   (wr_valid),
      .wr_ready_o   (wr_ready),
      .wr_data_i    (wr_data),
      .period_end_i (period_end),
      .cr_o         (cr),
      .cr_upd_o     (cr_upd),
      .busy_o       (busy),
      .elem_cnt_o   (elem_cnt),
      .lw_o         (lw),
      .udf_o        (udf),
      .udf_clr_i    (udf_clr)
   );

   function automatic logic [63:0] mk(input logic [15:0] c0, input logic [15:0] c1,
                                      input logic [15:0] c2, input logic [15:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic pulse_pe();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
   endtask

   initial begin
      set_a = mk(16'h0010, 16'h0020, 16'h0030, 16'h0040);
      set_b = mk(16'h0050, 16'h0060, 16'h0070, 16'h0080);
      set_c = mk(16'h1111, 16'h1112, 16'h1113, 16'h1114);
      set_d = mk(16'h2221, 16'h2222, 16'h2223, 16'h2224);
      set_e = mk(16'h3331, 16'h3332, 16'h3333, 16'h3334);
      set_g = mk(16'hA001, 16'hA002, 16'hA003, 16'hA004);

      // reset state
      #12;
      chk("rst_cr", cr, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_cnt", {60'd0, elem_cnt}, 64'd0);
      chk("rst_ready", {63'd0, wr_ready}, 64'd1);
      chk("rst_udf_lw_upd", {61'd0, udf, lw, cr_upd}, 64'd0);
      rst_n = 1'b1;
      tick();

      // basic load, hold 2 periods, advance, underflow
      rpt = 8'd2;
      push(set_a);
      push(set_b);
      chk("t1_cnt2", {60'd0, elem_cnt}, 64'd2);
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_busy", {63'd0, busy}, 64'd1);
      tick();
      chk("t1_lw", {63'd0, lw}, 64'd1);
      pulse_pe();
      chk("t1_crA", cr, set_a);
      chk("t1_updA", {63'd0, cr_upd}, 64'd1);
      chk("t1_cnt1", {60'd0, elem_cnt}, 64'd1);
      tick();
      chk("t1_upd_low", {63'd0, cr_upd}, 64'd0);
      repeat (3) tick();
      pulse_pe();
      chk("t1_holdA", cr, set_a);
      chk("t1_hold_noupd", {63'd0, cr_upd}, 64'd0);
      repeat (4) tick();
      pulse_pe();
      chk("t1_crB", cr, set_b);
      chk("t1_cnt0", {60'd0, elem_cnt}, 64'd0);
      repeat (4) tick();
      pulse_pe();
      chk("t1_holdB_noudf", {63'd0, udf}, 64'd0);
      repeat (4) tick();
      pulse_pe();
      chk("t1_udf", {63'd0, udf}, 64'd1);
      chk("t1_udf_crB", cr, set_b);
      chk("t1_udf_busy", {63'd0, busy}, 64'd1);
      udf_clr = 1'b1; tick(); udf_clr = 1'b0;
      chk("t1_udf_clr", {63'd0, udf}, 64'd0);

      // rpt 0 behaves as 1
      rpt = 8'd0;
      push(set_c);
      push(set_d);
      push(set_e);
      chk("t2_cnt3", {60'd0, elem_cnt}, 64'd3);
      pulse_pe();
      chk("t2_crC", cr, set_c);
      chk("t2_cnt2", {60'd0, elem_cnt}, 64'd2);
      tick();
      pulse_pe();
      chk("t2_crD", cr, set_d);
      chk("t2_cnt1", {60'd0, elem_cnt}, 64'd1);
      tick();
      pulse_pe();
      chk("t2_crE", cr, set_e);
      chk("t2_cnt0", {60'd0, elem_cnt}, 64'd0);
      tick();
      pulse_pe();
      chk("t2_udf", {63'd0, udf}, 64'd1);
      udf_clr = 1'b1; tick(); udf_clr = 1'b0;

      // full FIFO
      for (int i = 0; i < 8; i++) push(mk(16'(i), 16'(i + 16), 16'(i + 32), 16'(i + 48)));
      chk("t3_cnt8", {60'd0, elem_cnt}, 64'd8);
      chk("t3_ready0", {63'd0, wr_ready}, 64'd0);
      push(64'hDEAD_BEEF_DEAD_BEEF);
      chk("t3_9th_ignored", {60'd0, elem_cnt}, 64'd8);
      pulse_pe();
      chk("t3_cr_f0", cr, mk(16'd0, 16'd16, 16'd32, 16'd48));
      chk("t3_cnt7", {60'd0, elem_cnt}, 64'd7);
      chk("t3_ready1", {63'd0, wr_ready}, 64'd1);
      push(mk(16'd8, 16'd24, 16'd40, 16'd56));
      chk("t3_refill8", {60'd0, elem_cnt}, 64'd8);

      // stop and period_end together in RUN
      stop = 1'b1; period_end = 1'b1; tick(); stop = 1'b0; period_end = 1'b0;
      chk("t4_busy0", {63'd0, busy}, 64'd0);
      chk("t4_cr_kept", cr, mk(16'd0, 16'd16, 16'd32, 16'd48));
      chk("t4_no_upd", {63'd0, cr_upd}, 64'd0);
      chk("t4_cnt8", {60'd0, elem_cnt}, 64'd8);
      pulse_pe();
      chk("t4_idle_ignores_pe", cr, mk(16'd0, 16'd16, 16'd32, 16'd48));
      start = 1'b1; tick(); start = 1'b0;
      pulse_pe();
      chk("t4_cr_f1", cr, mk(16'd1, 16'd17, 16'd33, 16'd49));
      chk("t4_cnt7", {60'd0, elem_cnt}, 64'd7);

      // flush with simultaneous push, from ARMED
      stop = 1'b1; tick(); stop = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      flush = 1'b1; wr_valid = 1'b1; wr_data = 64'h1234_5678_9ABC_DEF0;
      tick();
      flush = 1'b0; wr_valid = 1'b0;
      chk("t5_cnt0", {60'd0, elem_cnt}, 64'd0);
      pulse_pe();
      chk("t5_no_upd", {63'd0, cr_upd}, 64'd0);
      chk("t5_cr_kept", cr, mk(16'd1, 16'd17, 16'd33, 16'd49));
      chk("t5_no_udf", {63'd0, udf}, 64'd0);
      chk("t5_busy", {63'd0, busy}, 64'd1);

      // async reset mid-hold
      rpt = 8'd3;
      push(set_g);
      pulse_pe();
      chk("t6_crG", cr, set_g);
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_cr", cr, 64'd0);
      chk("t6_rst_busy", {63'd0, busy}, 64'd0);
      chk("t6_rst_flags", {61'd0, udf, lw, cr_upd}, 64'd0);
      chk("t6_rst_cnt", {60'd0, elem_cnt}, 64'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("t6_ready", {63'd0, wr_ready}, 64'd1);
      chk("t6_busy0", {63'd0, busy}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
